// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - Shared types and constants for the UART program loader.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int         LEN_W             = 16;

  typedef logic [1:0] lane_idx_t;

endpackage

// File: rtl/prog_word_assembler.sv
// rtl/prog_word_assembler.sv - Packs little-endian bytes into 32-bit words.
module prog_word_assembler
  import prog_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word
);

  lane_idx_t   lane_q, lane_d;
  logic [23:0] lanes_q, lanes_d;

  // Only three lanes are stored; the fourth byte is merged on the fly and registered by the caller.
  always_comb begin
    lane_d  = lane_q;
    lanes_d = lanes_q;
    if (clear) begin
      lane_d = '0;
    end else if (byte_valid) begin
      lane_d = lane_q + lane_idx_t'(1);
      case (lane_q)
        2'd0:    lanes_d[7:0]   = byte_data;
        2'd1:    lanes_d[15:8]  = byte_data;
        2'd2:    lanes_d[23:16] = byte_data;
        default: lanes_d        = lanes_q;
      endcase
    end
  end

  assign word_valid = byte_valid && !clear && (lane_q == 2'd3);
  assign word       = {byte_data, lanes_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q  <= '0;
      lanes_q <= '0;
    end else begin
      lane_q  <= lane_d;
      lanes_q <= lanes_d;
    end
  end

endmodule

// File: rtl/prog_loader_ctrl.sv
// rtl/prog_loader_ctrl.sv - UART framed program download into instruction memory, holding the CPU meanwhile.
// Define PROG_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the payload.
module prog_loader_ctrl
  import prog_loader_pkg::*;
#(
  parameter int         MEM_DEPTH      = 1024,
  parameter int         TIMEOUT_CYCLES = 1_000_000,
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic [31:0] prog_addr,
  output logic [31:0] prog_data,
  output logic        prog_we,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_error,
  output logic        busy
);

  localparam int               AW      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int               TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [LEN_W:0]   MAX_LEN = (LEN_W + 1)'(MEM_DEPTH);
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam state_t           ST_POST = ST_CHECK;
`else
  localparam state_t           ST_POST = ST_DONE;
`endif

  state_t           state_q, state_d;
  logic [7:0]       len_lo_q, len_lo_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [AW-1:0]    prog_addr_q, prog_addr_d;
  logic [31:0]      prog_data_q, prog_data_d;
  logic             prog_we_q, prog_we_d;
  logic             load_done_q, load_done_d;
  logic             load_error_q, load_error_d;
  logic             busy_q, busy_d;
  logic             cpu_hold_q, cpu_hold_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [LEN_W-1:0] len_full;
  logic             asm_clear, asm_valid, word_valid;
  logic [31:0]      word;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]       csum_q, csum_d;
`endif

  assign len_full  = {rx_data, len_lo_q};
  assign asm_clear = (state_q != ST_DATA);
  assign asm_valid = rx_valid && (state_q == ST_DATA);

  prog_word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (asm_clear),
    .byte_valid (asm_valid),
    .byte_data  (rx_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_comb begin
    state_d      = state_q;
    len_lo_d     = len_lo_q;
    count_d      = count_q;
    idx_d        = idx_q;
    prog_addr_d  = prog_addr_q;
    prog_data_d  = prog_data_q;
    prog_we_d    = 1'b0;
    load_done_d  = 1'b0;
    load_error_d = load_error_q;
    tmo_d        = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
    csum_d       = csum_q;
`endif
    case (state_q)
      ST_IDLE: if (rx_valid && rx_data == SYNC_BYTE) begin
        state_d      = ST_LEN_LO;
        load_error_d = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
        csum_d       = 8'h00;
`endif
      end
      ST_LEN_LO: if (rx_valid) begin
        len_lo_d = rx_data;
        state_d  = ST_LEN_HI;
      end
      ST_LEN_HI: if (rx_valid) begin
        count_d = len_full;
        if (len_full == '0)                 state_d = ST_POST;
        else if ({1'b0, len_full} > MAX_LEN) state_d = ST_ERROR;
        else begin
          state_d = ST_DATA;
          idx_d   = '0;
        end
      end
      ST_DATA: begin
`ifdef PROG_LOADER_CHECKSUM_EN
        if (rx_valid) csum_d = csum_q ^ rx_data;
`endif
        if (word_valid) begin
          prog_we_d   = 1'b1;
          prog_data_d = word;
          prog_addr_d = idx_q;
          idx_d       = idx_q + AW'(1);
          if (LEN_W'(idx_q) == count_q - LEN_W'(1)) state_d = ST_POST;
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      ST_CHECK: if (rx_valid) state_d = (rx_data == csum_q) ? ST_DONE : ST_ERROR;
`endif
      ST_DONE: begin
        load_done_d = 1'b1;
        state_d     = ST_IDLE;
      end
      ST_ERROR: begin
        load_error_d = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Inter-byte watchdog: any accepted byte restarts it; a partial word is simply abandoned.
    if (state_q inside {ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CHECK} && !rx_valid) begin
      tmo_d = tmo_q + TW'(1);
      if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) state_d = ST_ERROR;
    end

    busy_d     = (state_d != ST_IDLE);
    cpu_hold_d = busy_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      len_lo_q     <= '0;
      count_q      <= '0;
      idx_q        <= '0;
      prog_addr_q  <= '0;
      prog_data_q  <= '0;
      prog_we_q    <= 1'b0;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
      busy_q       <= 1'b0;
      cpu_hold_q   <= 1'b0;
      tmo_q        <= '0;
    end else begin
      state_q      <= state_d;
      len_lo_q     <= len_lo_d;
      count_q      <= count_d;
      idx_q        <= idx_d;
      prog_addr_q  <= prog_addr_d;
      prog_data_q  <= prog_data_d;
      prog_we_q    <= prog_we_d;
      load_done_q  <= load_done_d;
      load_error_q <= load_error_d;
      busy_q       <= busy_d;
      cpu_hold_q   <= cpu_hold_d;
      tmo_q        <= tmo_d;
    end
  end

`ifdef PROG_LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst) csum_q <= 8'h00;
    else     csum_q <= csum_d;
  end
`endif

  assign prog_addr  = {{(32 - AW){1'b0}}, prog_addr_q};
  assign prog_data  = prog_data_q;
  assign prog_we    = prog_we_q;
  assign cpu_hold   = cpu_hold_q;
  assign load_done  = load_done_q;
  assign load_error = load_error_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_prog_loader_ctrl.sv
// tb/tb_prog_loader_ctrl.sv - Directed and randomized frame checks for prog_loader_ctrl (honours PROG_LOADER_CHECKSUM_EN).
module tb_prog_loader_ctrl;

  localparam int TMO   = 50;
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic [31:0] prog_addr, prog_data;
  logic        prog_we, cpu_hold, load_done, load_error, busy;

  int tests = 0;
  int fails = 0;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          done_cnt = 0;
  int          done_hold_cnt = 0;
  int          we_run_cnt = 0;
  logic        prev_we = 1'b0;

  always #5 clk = ~clk;

  prog_loader_ctrl #(.MEM_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .prog_we    (prog_we),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_error (load_error),
    .busy       (busy)
  );

  always @(negedge clk) begin
    if (prog_we) begin
      wr_addr_q.push_back(prog_addr);
      wr_data_q.push_back(prog_data);
      if (prev_we) we_run_cnt++;
    end
    prev_we = prog_we;
    if (load_done) begin
      done_cnt++;
      if (cpu_hold || busy) done_hold_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    wr_addr_q.delete();
    wr_data_q.delete();
    done_cnt      = 0;
    done_hold_cnt = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_header(input int len);
    send_byte(8'hA5, 0);
    check("hold_after_sync", cpu_hold, 1);
    check("busy_after_sync", busy, 1);
    check("err_clr_after_sync", load_error, 0);
    send_byte(len[7:0], $urandom_range(0, 3));
    send_byte(len[15:8], $urandom_range(0, 3));
  endtask

  task automatic send_payload(input logic [31:0] words[$], input int max_gap);
    logic [7:0] csum;
    logic [7:0] b;
    csum = 8'h00;
    foreach (words[i]) begin
      for (int k = 0; k < 4; k++) begin
        b    = words[i][8*k +: 8];
        csum = csum ^ b;
        send_byte(b, $urandom_range(0, max_gap));
      end
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(csum, 0);
`endif
  endtask

  task automatic expect_frame(input logic [31:0] words[$], input int exp_done, input int exp_err);
    repeat (6) @(negedge clk);
    check("write_count", wr_addr_q.size(), words.size());
    for (int i = 0; i < words.size() && i < wr_addr_q.size(); i++) begin
      check("write_addr", wr_addr_q[i], i);
      check("write_data", wr_data_q[i], words[i]);
    end
    check("done_count", done_cnt, exp_done);
    check("done_with_hold", done_hold_cnt, 0);
    check("load_error", load_error, exp_err);
    check("busy_idle", busy, 0);
    check("hold_idle", cpu_hold, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_addr"}, prog_addr, 0);
    check({tag, "_data"}, prog_data, 0);
    check({tag, "_we"}, prog_we, 0);
    check({tag, "_hold"}, cpu_hold, 0);
    check({tag, "_done"}, load_done, 0);
    check({tag, "_err"}, load_error, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    logic [31:0] words[$];
    int          n;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Two-word example frame.
    clear_mon();
    words = '{32'h00000013, 32'h00100093};
    send_header(2);
    send_payload(words, 2);
    expect_frame(words, 1, 0);

    // Zero-length frame: done pulse two cycles after the final header byte.
    clear_mon();
    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(8'h00, 0);
`endif
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = 8'h00;
    @(negedge clk);
    rx_valid = 1'b0;
    check("zero_len_done_early", load_done, 0);
    @(negedge clk);
    check("zero_len_done", load_done, 1);
    check("zero_len_hold", cpu_hold, 0);
    check("zero_len_busy", busy, 0);
    words.delete();
    expect_frame(words, 1, 0);

    // Oversize length (1025 words).
    clear_mon();
    send_header(1025);
    repeat (3) @(negedge clk);
    check("oversize_err", load_error, 1);
    check("oversize_hold", cpu_hold, 0);
    words.delete();
    expect_frame(words, 0, 1);

    // Sticky error cleared by the next frame; SYNC-valued payload is plain data.
    clear_mon();
    words = '{32'hA5A5A5A5, 32'h000000A5, $urandom()};
    send_header(3);
    send_payload(words, 3);
    expect_frame(words, 1, 0);

    // Timeout after a partial word.
    clear_mon();
    send_header(1);
    send_byte(8'h13, 0);
    send_byte(8'h00, 0);
    repeat (TMO - 2) @(negedge clk);
    check("tmo_not_yet_err", load_error, 0);
    check("tmo_not_yet_busy", busy, 1);
    repeat (5) @(negedge clk);
    check("tmo_err", load_error, 1);
    check("tmo_busy", busy, 0);
    words.delete();
    expect_frame(words, 0, 1);

    // Reset mid-word, then a clean frame starts at address 0.
    clear_mon();
    send_header(2);
    send_byte(8'h13, 0);
    send_byte(8'h00, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("midrst");
    rst = 1'b0;
    check("midrst_no_write", wr_addr_q.size(), 0);
    clear_mon();
    words = '{$urandom(), $urandom()};
    send_header(2);
    send_payload(words, 3);
    expect_frame(words, 1, 0);

    // Randomized frames.
    for (int f = 0; f < 4; f++) begin
      clear_mon();
      words.delete();
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) words.push_back($urandom());
      send_header(n);
      send_payload(words, 3);
      expect_frame(words, 1, 0);
    end

    // Largest legal frame.
    clear_mon();
    words.delete();
    for (int i = 0; i < DEPTH; i++) words.push_back($urandom());
    send_header(DEPTH);
    send_payload(words, 0);
    expect_frame(words, 1, 0);
    check("no_back_to_back_we", we_run_cnt, 0);

`ifdef PROG_LOADER_CHECKSUM_EN
    // Wrong checksum: the word stays written but the frame errors.
    clear_mon();
    send_header(1);
    send_byte(8'h13, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h12, 0);
    words = '{32'h00000013};
    expect_frame(words, 0, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
